// File: rtl/glitch_sweep_ctrl.sv
// rtl/glitch_sweep_ctrl.sv - glitch trigger-delay sweep sequencer
// Optional SWEEP_STOP_ON_SUCCESS_EN: the first recorded success ends the sweep.
module glitch_sweep_ctrl #(
    parameter logic [31:0] START_DELAY    = 32'd0,
    parameter logic [31:0] END_DELAY      = 32'd1000,
    parameter logic [31:0] STEP           = 32'd1,
    parameter logic [31:0] RESET_CYCLES   = 32'd64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        trigger,
    input  logic        delayed_trigger,
    input  logic        success,
    output logic [31:0] delay_cycles,
    output logic        set_delay,
    output logic        trigger_arm,
    output logic        success_arm,
    output logic        target_rst_n,
    output logic        busy,
    output logic        found,
    output logic [31:0] found_delay,
    output logic [15:0] attempt_count,
    output logic [15:0] success_count
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        RESET_TGT,
        ARM,
        WAIT_TRIG,
        WAIT_GLITCH,
        WAIT_RESULT,
        NEXT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [32:0] next_delay;
    logic        timeout;

    // 33-bit sum so a carry out of the 32-bit delay ends the sweep instead of wrapping
    assign next_delay = {1'b0, delay_cycles} + {1'b0, STEP};
    assign timeout    = (cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            delay_cycles  <= '0;
            set_delay     <= 1'b0;
            trigger_arm   <= 1'b0;
            success_arm   <= 1'b0;
            target_rst_n  <= 1'b1;
            busy          <= 1'b0;
            found         <= 1'b0;
            found_delay   <= '0;
            attempt_count <= '0;
            success_count <= '0;
        end else begin
            set_delay <= 1'b0;
            if (stop && busy) begin
                state        <= IDLE;
                trigger_arm  <= 1'b0;
                success_arm  <= 1'b0;
                target_rst_n <= 1'b1;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            delay_cycles  <= START_DELAY;
                            found         <= 1'b0;
                            found_delay   <= '0;
                            attempt_count <= '0;
                            success_count <= '0;
                            set_delay     <= 1'b1;
                            busy          <= 1'b1;
                            state         <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (attempt_count != 16'hFFFF)
                            attempt_count <= attempt_count + 16'd1;
                        target_rst_n <= 1'b0;
                        cnt          <= '0;
                        state        <= RESET_TGT;
                    end
                    RESET_TGT: begin
                        // arms go high together with the reset release so they are up during ARM
                        if (cnt == RESET_CYCLES - 32'd1) begin
                            target_rst_n <= 1'b1;
                            trigger_arm  <= 1'b1;
                            success_arm  <= 1'b1;
                            state        <= ARM;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    ARM: begin
                        cnt   <= '0;
                        state <= WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        if (trigger) begin
                            trigger_arm <= 1'b0;
                            cnt         <= '0;
                            state       <= WAIT_GLITCH;
                        end else if (timeout) begin
                            trigger_arm <= 1'b0;
                            success_arm <= 1'b0;
                            state       <= NEXT;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    WAIT_GLITCH: begin
                        if (delayed_trigger) begin
                            cnt   <= '0;
                            state <= WAIT_RESULT;
                        end else if (timeout) begin
                            trigger_arm <= 1'b0;
                            success_arm <= 1'b0;
                            state       <= NEXT;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    WAIT_RESULT: begin
                        if (success) begin
                            if (!found) begin
                                found       <= 1'b1;
                                found_delay <= delay_cycles;
                            end
                            if (success_count != 16'hFFFF)
                                success_count <= success_count + 16'd1;
                            trigger_arm <= 1'b0;
                            success_arm <= 1'b0;
`ifdef SWEEP_STOP_ON_SUCCESS_EN
                            busy  <= 1'b0;
                            state <= DONE;
`else
                            state <= NEXT;
`endif
                        end else if (timeout) begin
                            trigger_arm <= 1'b0;
                            success_arm <= 1'b0;
                            state       <= NEXT;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    NEXT: begin
                        trigger_arm <= 1'b0;
                        success_arm <= 1'b0;
                        if (next_delay[32] || (next_delay[31:0] > END_DELAY)) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            delay_cycles <= next_delay[31:0];
                            set_delay    <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                    DONE: begin
                        busy        <= 1'b0;
                        trigger_arm <= 1'b0;
                        success_arm <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// tb/tb_glitch_sweep_ctrl.sv - directed self-checking bench for glitch_sweep_ctrl
module tb_glitch_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 0, a_stop = 0, a_trig = 0, a_dtrig = 0, a_succ = 0;
    logic [31:0] a_delay, a_found_delay;
    logic        a_set_delay, a_trigger_arm, a_success_arm, a_target_rst_n, a_busy, a_found;
    logic [15:0] a_attempts, a_successes;

    logic        b_start = 0;
    logic        b_zero = 0;
    logic [31:0] b_delay, b_found_delay;
    logic        b_set_delay, b_trigger_arm, b_success_arm, b_target_rst_n, b_busy, b_found;
    logic [15:0] b_attempts, b_successes;

    glitch_sweep_ctrl #(
        .START_DELAY(32'd10), .END_DELAY(32'd12), .STEP(32'd1),
        .RESET_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd8)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
        .trigger(a_trig), .delayed_trigger(a_dtrig), .success(a_succ),
        .delay_cycles(a_delay), .set_delay(a_set_delay),
        .trigger_arm(a_trigger_arm), .success_arm(a_success_arm),
        .target_rst_n(a_target_rst_n), .busy(a_busy), .found(a_found),
        .found_delay(a_found_delay), .attempt_count(a_attempts), .success_count(a_successes)
    );

    glitch_sweep_ctrl #(
        .START_DELAY(32'hFFFF_FFF0), .END_DELAY(32'hFFFF_FFFF), .STEP(32'h20),
        .RESET_CYCLES(32'd4), .TIMEOUT_CYCLES(32'd8)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_zero),
        .trigger(b_zero), .delayed_trigger(b_zero), .success(b_zero),
        .delay_cycles(b_delay), .set_delay(b_set_delay),
        .trigger_arm(b_trigger_arm), .success_arm(b_success_arm),
        .target_rst_n(b_target_rst_n), .busy(b_busy), .found(b_found),
        .found_delay(b_found_delay), .attempt_count(b_attempts), .success_count(b_successes)
    );

    int errors = 0;
    int checks = 0;

    int          a_pulses = 0;
    int          b_pulses = 0;
    logic [31:0] a_loaded [0:7];

    always @(negedge clk) begin
        if (a_set_delay) begin
            if (a_pulses < 8) a_loaded[a_pulses] = a_delay;
            a_pulses = a_pulses + 1;
        end
        if (b_set_delay) b_pulses = b_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_a();
        a_pulses = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_idle(input string tag);
        int n = 0;
        while (a_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, a_busy}, 32'd0);
    endtask

    task automatic wait_a_arm(input logic [31:0] d, input string tag);
        int n = 0;
        while (!(a_trigger_arm && a_delay == d) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, a_trigger_arm}, 32'd1);
    endtask

    // trigger in WAIT_TRIG, glitch in WAIT_GLITCH, success either on the first
    // WAIT_RESULT cycle or on the cycle where its timeout also fires
    task automatic run_attempt(input bit late_success);
        @(negedge clk);
        a_trig = 1'b1;
        @(negedge clk);
        a_trig  = 1'b0;
        a_dtrig = 1'b1;
        @(negedge clk);
        a_dtrig = 1'b0;
        if (late_success) repeat (7) @(negedge clk);
        a_succ = 1'b1;
        @(negedge clk);
        a_succ = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_delay", a_delay, 32'd0);
        check("rst_set_delay", {31'd0, a_set_delay}, 32'd0);
        check("rst_arms", {30'd0, a_trigger_arm, a_success_arm}, 32'd0);
        check("rst_target_rst_n", {31'd0, a_target_rst_n}, 32'd1);
        check("rst_busy_found", {30'd0, a_busy, a_found}, 32'd0);
        check("rst_counts", {a_attempts, a_successes}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // carry out of the 32-bit delay: one attempt, no wrap
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int n = 0; n < 400 && b_busy; n++) @(negedge clk);
        check("carry_busy", {31'd0, b_busy}, 32'd0);
        check("carry_pulses", b_pulses, 32'd1);
        check("carry_attempts", {16'd0, b_attempts}, 32'd1);
        check("carry_delay", b_delay, 32'hFFFF_FFF0);
        check("carry_found", {31'd0, b_found} | b_found_delay | {16'd0, b_successes}, 32'd0);
        check("carry_outs", {29'd0, b_trigger_arm, b_success_arm, b_target_rst_n}, 32'd1);

        // start together with stop in IDLE is ignored
        a_start = 1'b1;
        a_stop  = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_stop  = 1'b0;
        @(negedge clk);
        check("start_stop_busy", {30'd0, a_busy, a_set_delay}, 32'd0);

        // plain sweep, no trigger ever
        start_a();
        check("t_load_set_delay", {31'd0, a_set_delay}, 32'd1);
        check("t_load_busy", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        check("t_rst_first", {30'd0, a_set_delay, a_target_rst_n}, 32'd0);
        repeat (3) @(negedge clk);
        check("t_rst_last", {31'd0, a_target_rst_n}, 32'd0);
        @(negedge clk);
        check("t_arm", {29'd0, a_target_rst_n, a_trigger_arm, a_success_arm}, 32'd7);
        wait_a_idle("sweep_end");
        check("sweep_pulses", a_pulses, 32'd3);
        check("sweep_d0", a_loaded[0], 32'd10);
        check("sweep_d1", a_loaded[1], 32'd11);
        check("sweep_d2", a_loaded[2], 32'd12);
        check("sweep_attempts", {16'd0, a_attempts}, 32'd3);
        check("sweep_found", {31'd0, a_found}, 32'd0);
        check("sweep_arms", {30'd0, a_trigger_arm, a_success_arm}, 32'd0);

        // success on the delay=11 attempt
        @(negedge clk);
        start_a();
        wait_a_arm(32'd11, "arm_11");
        run_attempt(1'b0);
`ifdef SWEEP_STOP_ON_SUCCESS_EN
        wait_a_idle("succ_end");
        check("succ_found", {31'd0, a_found}, 32'd1);
        check("succ_found_delay", a_found_delay, 32'd11);
        check("succ_count", {16'd0, a_successes}, 32'd1);
        check("succ_attempts", {16'd0, a_attempts}, 32'd2);
`else
        // delay=12 success lands in the same cycle as the WAIT_RESULT timeout
        wait_a_arm(32'd12, "arm_12");
        run_attempt(1'b1);
        wait_a_idle("succ_end");
        check("succ_found", {31'd0, a_found}, 32'd1);
        check("succ_found_delay", a_found_delay, 32'd11);
        check("succ_count", {16'd0, a_successes}, 32'd2);
        check("succ_attempts", {16'd0, a_attempts}, 32'd3);
`endif

        // stop during RESET_TGT
        @(negedge clk);
        start_a();
        repeat (3) @(negedge clk);
        check("stop_pre_rst_n", {31'd0, a_target_rst_n}, 32'd0);
        a_stop = 1'b1;
        @(negedge clk);
        a_stop = 1'b0;
        check("stop_outs", {28'd0, a_target_rst_n, a_trigger_arm, a_success_arm, a_busy}, 32'd8);
        check("stop_attempts", {16'd0, a_attempts}, 32'd1);

        // rst during WAIT_RESULT
        @(negedge clk);
        start_a();
        wait_a_arm(32'd10, "arm_10");
        @(negedge clk);
        a_trig = 1'b1;
        @(negedge clk);
        a_trig  = 1'b0;
        a_dtrig = 1'b1;
        @(negedge clk);
        a_dtrig = 1'b0;
        check("wr_success_arm", {31'd0, a_success_arm}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstmid_outs", {28'd0, a_target_rst_n, a_trigger_arm, a_success_arm, a_busy}, 32'd8);
        check("rstmid_counts", {a_attempts, a_successes}, 32'd0);
        check("rstmid_delay", a_delay, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_ctrl.md
# glitch_sweep_ctrl

Sequencer that drives the glitch chain by sweeping the trigger delay over a programmed range, one attempt per delay value. Per attempt it loads `delay_cycles`/`set_delay` into `trigger_delay`, resets the target, arms the trigger and success edge detectors, and waits for a trigger, the delayed glitch and a success indication, each bounded by a timeout. It sits upstream of `trigger_delay` and downstream of the success `detect_edge`, and is the source of `delay_cycles`, `set_delay`, `trigger_arm` and `success_arm` in `top`.

## Interface
- `START_DELAY`, 0: first delay value, in clk cycles.
- `END_DELAY`, 1000: last delay value, inclusive.
- `STEP`, 1: delay increment per attempt. Must be ≥1.
- `RESET_CYCLES`, 64: cycles `target_rst_n` is held low per attempt.
- `TIMEOUT_CYCLES`, 48000: per-wait timeout (1 ms at 48 MHz).
- `clk` in 1: 48 MHz system clock.
- `rst` in 1: reset. Synchronous, active-low.
- `start` in 1: one-cycle pulse that begins a sweep. Ignored while `busy`.
- `stop` in 1: aborts the sweep.
- `trigger` in 1: pulse from the trigger `detect_edge`.
- `delayed_trigger` in 1: pulse from `trigger_delay` marking that the glitch fired.
- `success` in 1: pulse from the success `detect_edge`.
- `delay_cycles` out 32: current delay value.
- `set_delay` out 1: one-cycle load strobe to `trigger_delay`.
- `trigger_arm` out 1: level; arms the trigger detector.
- `success_arm` out 1: level; arms the success detector.
- `target_rst_n` out 1: target reset, active-low.
- `busy` out 1: high while a sweep is in progress.
- `found` out 1: at least one success has been recorded.
- `found_delay` out 32: delay of the first success.
- `attempt_count` out 16: attempts started, saturating at 0xFFFF.
- `success_count` out 16: successes recorded, saturating at 0xFFFF.

## Operation
- Reset values: `delay_cycles`=0, `set_delay`=0, `trigger_arm`=0, `success_arm`=0, `target_rst_n`=1, `busy`=0, `found`=0, `found_delay`=0, both counts 0. State is IDLE.
- **IDLE**
  - On `start`: `delay_cycles`←START_DELAY; clear `found`, `found_delay` and both counts; go to LOAD.
- **LOAD**
  - Assert `set_delay` for exactly one cycle.
  - Increment `attempt_count`.
  - Go to RESET_TGT.
- **RESET_TGT**
  - Hold `target_rst_n`=0 for RESET_CYCLES cycles, then release it and go to ARM.
- **ARM**
  - Raise `trigger_arm` and `success_arm`; go to WAIT_TRIG.
- **WAIT_TRIG**
  - On `trigger`: drop `trigger_arm`; go to WAIT_GLITCH.
  - On timeout: go to NEXT.
- **WAIT_GLITCH**
  - On `delayed_trigger`: go to WAIT_RESULT.
  - On timeout: go to NEXT.
- **WAIT_RESULT**
  - On `success`: record the success, then go to DONE if `SWEEP_STOP_ON_SUCCESS_EN` is defined, otherwise to NEXT.
  - On timeout: go to NEXT.
- **NEXT**
  - Drop both arms.
  - Compute `delay_cycles`+STEP in 33 bits. On carry or a result > END_DELAY, go to DONE. Otherwise load the new value and go to LOAD.
- **DONE**
  - `busy`=0, both arms 0.
  - Results hold until the next `start`. Go to IDLE.
- Recording a success: if `found`=0, set `found`=1 and `found_delay`←`delay_cycles`. Always increment `success_count`, saturating.
- Timeout counter: cleared on every entry to a WAIT_* state. Timeout fires when the counter reaches TIMEOUT_CYCLES-1.
- `busy` is 1 in every state except IDLE and DONE.
- `stop` in any busy state: IDLE on the next edge. Arms drop, `target_rst_n`=1, results are retained.
- Simultaneous events:
  - Event and timeout in the same cycle: the event wins.
  - `stop` together with any other condition: `stop` wins.
  - `start` and `stop` together in IDLE: `start` is ignored.
- START_DELAY > END_DELAY: exactly one attempt at START_DELAY, then DONE.
- `rst` low mid-sweep: all outputs take their reset values on that edge, including `target_rst_n`=1.

## Timing
- `start` at edge N: LOAD at N+1; `set_delay` high during cycle N+1 only.
- `target_rst_n` is low for cycles N+2 … N+1+RESET_CYCLES.
- Arms are high from cycle N+2+RESET_CYCLES.
- Event sampled at edge M: the state transition takes effect at M+1.
- Delay-to-delay period, all waits timing out: 1 + RESET_CYCLES + 1 + TIMEOUT_CYCLES + 1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `SWEEP_STOP_ON_SUCCESS_EN` defined: the first success ends the sweep (DONE).
- Undefined: the sweep runs to END_DELAY. `found_delay` holds the first success; `success_count` totals all successes.

## Test plan
- START=10, END=12, STEP=1, no `trigger` ever → 3 `set_delay` pulses carrying 10, 11, 12; `attempt_count`=3; `found`=0; `busy` falls after the third timeout.
- `trigger`, `delayed_trigger` and `success` all pulsed on the delay=11 attempt, macro defined → DONE with `found`=1, `found_delay`=11, `success_count`=1, `attempt_count`=2.
- Same stimulus, macro undefined, plus `success` on the delay=12 attempt → `found_delay`=11, `success_count`=2, `attempt_count`=3.
- `success` and timeout in the same cycle of WAIT_RESULT → counted as a success.
- START=0xFFFFFFF0, END=0xFFFFFFFF, STEP=0x20 → one attempt, carry detected, DONE; no wrap to a small delay.
- `stop` during RESET_TGT, and separately `rst`=0 during WAIT_RESULT → next edge: `target_rst_n`=1, arms 0, `busy`=0; after reset all counts are 0.
